// File: rtl/spi_slave.sv
// SFR-mapped SPI slave: synchronised SCK/SSn/MOSI, 8-bit frames in modes 0-3,
// one-byte TX buffer, RX data/flags behind the byte-wide SFR bus, interrupt out.
module spi_slave #(
  parameter logic [7:0] SSCR_ADDR = 8'h02,
  parameter logic [7:0] SSSR_ADDR = 8'h03,
  parameter logic [7:0] SSDR_ADDR = 8'h04
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       psel,
  input  logic       penable,
  input  logic       WE,
  input  logic       RE,
  input  logic [7:0] ADDRD,
  input  logic [7:0] DATABI,
  output logic [7:0] DATAB,
  input  logic       SCK,
  input  logic       SSn,
  input  logic       MOSI,
  output logic       MISO,
  output logic       INT,
  input  logic       ES,
  output logic       spis_busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_sck_s, r_ss_s, r_mosi_s;
  logic       r_sck_d, r_ss_d;
  logic       r_spie, r_spe, r_dord, r_cpol, r_cpha;
  logic       r_spif, r_ovr, r_txe;
  logic [7:0] r_txbuf, r_tx_sh, r_rx_sh, r_rx_data;
  logic [2:0] r_bcnt;
  logic       r_miso, r_int;

  logic       w_unused_re;
  logic       w_apb_wr, w_wr_sscr, w_wr_sssr, w_wr_ssdr;
  logic       w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
  logic       w_sample, w_drive, w_active, w_enter;
  logic       w_byte_done, w_load, w_clr_spif, w_clr_ovr;
  logic [7:0] w_rx_next;
  logic       w_busy;

  assign w_unused_re = RE;

  assign w_apb_wr  = psel & ~penable & WE;
  assign w_wr_sscr = w_apb_wr && (ADDRD == SSCR_ADDR);
  assign w_wr_sssr = w_apb_wr && (ADDRD == SSSR_ADDR);
  assign w_wr_ssdr = w_apb_wr && (ADDRD == SSDR_ADDR);
  assign w_clr_spif = w_wr_sssr & DATABI[0];
  assign w_clr_ovr  = w_wr_sssr & DATABI[1];

  assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
  assign w_ss_fall  = ~r_ss_s[1] & r_ss_d;
  assign w_ss_rise  = r_ss_s[1] & ~r_ss_d;
  assign w_sample   = (r_cpol == r_cpha) ? w_sck_rise : w_sck_fall;
  assign w_drive    = (r_cpol == r_cpha) ? w_sck_fall : w_sck_rise;

  assign w_active    = (r_state == ACTIVE);
  assign w_enter     = (r_state == IDLE) & r_spe & w_ss_fall;
  assign w_rx_next   = r_dord ? {r_mosi_s[1], r_rx_sh[7:1]} : {r_rx_sh[6:0], r_mosi_s[1]};
  assign w_byte_done = w_active & w_sample & ~w_ss_rise & (r_bcnt == 3'd7);
  // bcnt==0 on a drive edge is both the cpha=1 first-bit load and the cpha=0
  // post-byte reload; cpha=0 additionally preloads on frame entry.
  assign w_load = r_spe & ((w_enter & ~r_cpha) |
                           (w_active & w_drive & ~w_ss_rise & (r_bcnt == 3'd0)));

  always_ff @(posedge CLK) begin
    if (!RESETn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_spe && w_ss_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (!r_spe || w_ss_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ACTIVE);
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_sck_s <= '0; r_ss_s <= '0; r_mosi_s <= '0;
      r_sck_d <= 1'b0; r_ss_d <= 1'b0;
      r_spie <= 1'b0; r_spe <= 1'b0; r_dord <= 1'b0; r_cpol <= 1'b0; r_cpha <= 1'b0;
      r_spif <= 1'b0; r_ovr <= 1'b0; r_txe <= 1'b1;
      r_txbuf <= '0; r_tx_sh <= '0; r_rx_sh <= '0; r_rx_data <= '0;
      r_bcnt <= '0; r_miso <= 1'b0; r_int <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[0], SCK};
      r_ss_s   <= {r_ss_s[0], SSn};
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_sck_d  <= r_sck_s[1];
      r_ss_d   <= r_ss_s[1];

      if (w_wr_sscr) begin
        r_spie <= DATABI[7]; r_spe <= DATABI[6]; r_dord <= DATABI[5];
        r_cpol <= DATABI[3]; r_cpha <= DATABI[2];
      end

      if (!r_spe) begin
        r_bcnt <= '0; r_rx_sh <= '0; r_tx_sh <= '0; r_rx_data <= '0;
        r_spif <= 1'b0; r_ovr <= 1'b0; r_txe <= 1'b1;
      end else begin
        if (w_load) begin
          r_tx_sh <= r_txe ? 8'h00 : r_txbuf;
          r_txe   <= 1'b1;
        end else if (w_active && w_drive) begin
          r_tx_sh <= r_dord ? {1'b0, r_tx_sh[7:1]} : {r_tx_sh[6:0], 1'b0};
        end

        if (w_active && w_ss_rise) begin
          r_bcnt  <= '0;
          r_rx_sh <= '0;
        end else if (w_active && w_sample) begin
          r_rx_sh <= w_rx_next;
          r_bcnt  <= r_bcnt + 3'd1;
          if (r_bcnt == 3'd7) r_rx_data <= w_rx_next;
        end

        r_spif <= w_byte_done | (r_spif & ~w_clr_spif);
        r_ovr  <= (w_byte_done & r_spif & ~w_clr_spif) | (r_ovr & ~w_clr_ovr);
      end

      // A coincident load has already taken the old contents above.
      if (w_wr_ssdr) begin
        r_txbuf <= DATABI;
        r_txe   <= 1'b0;
      end

      r_miso <= w_active ? (r_dord ? r_tx_sh[0] : r_tx_sh[7]) : 1'b0;
      r_int  <= r_spif & r_spie & ES;
    end
  end

  always_comb begin
    DATAB = '0;
    case (ADDRD)
      SSCR_ADDR: DATAB = {r_spie, r_spe, r_dord, 1'b0, r_cpol, r_cpha, 2'b00};
      SSSR_ADDR: DATAB = {5'b00000, r_txe, r_ovr, r_spif};
      SSDR_ADDR: DATAB = r_rx_data;
      default:   DATAB = '0;
    endcase
  end

  assign MISO      = r_miso;
  assign INT       = r_int;
  assign spis_busy = w_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master model with a
// mode/order vector table, a MISO/RX scoreboard and hand-timed corner cases.
module tb_spi_slave;

  localparam logic [7:0] SSCR = 8'h02;
  localparam logic [7:0] SSSR = 8'h03;
  localparam logic [7:0] SSDR = 8'h04;
  localparam int H = 8;

  logic       CLK = 1'b0;
  logic       RESETn, psel, penable, WE, RE, ES, SCK, SSn, MOSI;
  logic [7:0] ADDRD, DATABI, DATAB;
  logic       MISO, INT, spis_busy;

  spi_slave #(.SSCR_ADDR(SSCR), .SSSR_ADDR(SSSR), .SSDR_ADDR(SSDR)) dut (
    .CLK(CLK), .RESETn(RESETn), .psel(psel), .penable(penable), .WE(WE), .RE(RE),
    .ADDRD(ADDRD), .DATABI(DATABI), .DATAB(DATAB), .SCK(SCK), .SSn(SSn),
    .MOSI(MOSI), .MISO(MISO), .INT(INT), .ES(ES), .spis_busy(spis_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       cpol, cpha, dord;
    logic [7:0] tbuf, mosi, exp_miso, exp_rx;
  } vec_t;

  vec_t       vecs[10];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] q_miso[$];
  logic [7:0] q_rx[$];
  logic       m_cpol, m_cpha, m_dord;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  function automatic int bidx(input int i);
    return m_dord ? i : 7 - i;
  endfunction

  task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge CLK);
    psel = 1'b1; WE = 1'b1; ADDRD = addr; DATABI = data;
    @(posedge CLK);
    #1 psel = 1'b0; WE = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] addr, output logic [7:0] d);
    @(negedge CLK);
    ADDRD = addr; RE = 1'b1;
    #1 d = DATAB;
    RE = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    sfr_read(addr, d);
    chk(name, d, exp);
  endtask

  task automatic configure(input logic cpol, input logic cpha, input logic dord);
    m_cpol = cpol; m_cpha = cpha; m_dord = dord;
    @(negedge CLK);
    SCK = cpol;
    repeat (6) @(negedge CLK);
    sfr_write(SSCR, {1'b1, 1'b1, dord, 1'b0, cpol, cpha, 2'b00});
  endtask

  task automatic ss_low();
    @(negedge CLK);
    SSn = 1'b0;
  endtask

  task automatic ss_high();
    @(negedge CLK);
    SSn = 1'b1;
    repeat (H) @(negedge CLK);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    @(negedge CLK);
    if (!m_cpha) MOSI = tx[bidx(0)];
    repeat (H) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      if (!m_cpha) begin
        rx[bidx(i)] = MISO;
        SCK = ~SCK;
        repeat (H) @(negedge CLK);
        SCK = ~SCK;
        if (i < 7) MOSI = tx[bidx(i + 1)];
        repeat (H) @(negedge CLK);
      end else begin
        SCK = ~SCK;
        MOSI = tx[bidx(i)];
        repeat (H) @(negedge CLK);
        rx[bidx(i)] = MISO;
        SCK = ~SCK;
        repeat (H) @(negedge CLK);
      end
    end
  endtask

  task automatic frame(input logic [7:0] tx, input logic [7:0] exp_miso, input logic [7:0] exp_rx);
    logic [7:0] m, d;
    q_miso.push_back(exp_miso);
    q_rx.push_back(exp_rx);
    ss_low();
    repeat (5) @(negedge CLK);
    chk("busy_in_frame", {7'b0, spis_busy}, 8'h01);
    spi_byte(tx, 8, m);
    ss_high();
    chk("miso_byte", m, q_miso.pop_front());
    sfr_read(SSDR, d);
    chk("ssdr_rx", d, q_rx.pop_front());
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] m1, m2;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h2D, 8'hB4, 8'h2D, 8'hB4};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 8'hC8, 8'h13, 8'hC8, 8'h13};

    RESETn = 1'b0; psel = 1'b0; penable = 1'b0; WE = 1'b0; RE = 1'b0; ES = 1'b1;
    SCK = 1'b0; SSn = 1'b1; MOSI = 1'b0; ADDRD = '0; DATABI = '0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_dord = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RESETn = 1'b1;

    chk_reg("rst_sscr", SSCR, 8'h00);
    chk_reg("rst_sssr", SSSR, 8'h04);
    chk_reg("rst_ssdr", SSDR, 8'h00);
    chk("rst_miso", {7'b0, MISO}, 8'h00);
    chk("rst_int", {7'b0, INT}, 8'h00);
    chk("rst_busy", {7'b0, spis_busy}, 8'h00);

    for (int v = 0; v < 10; v++) begin
      configure(vecs[v].cpol, vecs[v].cpha, vecs[v].dord);
      if (v == 0) begin
        chk_reg("sscr_readback", SSCR, 8'hC0);
        chk_reg("unmapped_read", 8'h05, 8'h00);
      end
      sfr_write(SSDR, vecs[v].tbuf);
      chk_reg("txe_cleared", SSSR, 8'h00);
      frame(vecs[v].mosi, vecs[v].exp_miso, vecs[v].exp_rx);
      chk_reg("sssr_after_frame", SSSR, 8'h05);
      chk("int_set", {7'b0, INT}, 8'h01);
      sfr_write(SSSR, 8'h03);
      chk_reg("sssr_cleared", SSSR, 8'h04);
    end

    // back-to-back bytes, no buffer refill, no clear in between
    configure(1'b0, 1'b0, 1'b0);
    sfr_write(SSDR, 8'h5A);
    q_miso.push_back(8'h5A);
    q_miso.push_back(8'h00);
    ss_low();
    spi_byte(8'h11, 8, m1);
    spi_byte(8'h22, 8, m2);
    ss_high();
    chk("b2b_miso1", m1, q_miso.pop_front());
    chk("b2b_miso2", m2, q_miso.pop_front());
    chk_reg("b2b_ssdr", SSDR, 8'h22);
    chk_reg("b2b_sssr_ovr", SSSR, 8'h07);
    ES = 1'b0;
    repeat (3) @(negedge CLK);
    chk("int_masked_es", {7'b0, INT}, 8'h00);
    ES = 1'b1;
    repeat (3) @(negedge CLK);
    chk("int_es_back", {7'b0, INT}, 8'h01);
    sfr_write(SSSR, 8'h03);
    chk_reg("b2b_cleared", SSSR, 8'h04);

    // SSn released after 5 bits
    sfr_write(SSDR, 8'hC3);
    ss_low();
    spi_byte(8'hFF, 5, m1);
    ss_high();
    chk_reg("abort_sssr", SSSR, 8'h04);
    chk_reg("abort_ssdr_kept", SSDR, 8'h22);
    chk("abort_busy", {7'b0, spis_busy}, 8'h00);
    sfr_write(SSDR, 8'hC3);
    frame(8'h96, 8'hC3, 8'h96);
    sfr_write(SSSR, 8'h03);

    // software clear of spif in the same clock as the 8th detected sample
    sfr_write(SSDR, 8'h11);
    q_miso.push_back(8'h11);
    ss_low();
    spi_byte(8'hE7, 7, m1);
    m1[bidx(7)] = MISO;
    SCK = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    psel = 1'b1; WE = 1'b1; ADDRD = SSSR; DATABI = 8'h01;
    @(posedge CLK);
    #1 psel = 1'b0; WE = 1'b0;
    repeat (H) @(negedge CLK);
    SCK = 1'b0;
    repeat (H) @(negedge CLK);
    ss_high();
    chk("clr_race_miso", m1, q_miso.pop_front());
    chk_reg("clr_race_ssdr", SSDR, 8'hE7);
    chk_reg("clr_race_spif_wins", SSSR, 8'h05);
    sfr_write(SSSR, 8'h03);

    // reset mid-frame
    sfr_write(SSDR, 8'h77);
    ss_low();
    spi_byte(8'hAA, 4, m1);
    @(negedge CLK) RESETn = 1'b0;
    @(negedge CLK) RESETn = 1'b1;
    chk("mrst_miso", {7'b0, MISO}, 8'h00);
    chk("mrst_int", {7'b0, INT}, 8'h00);
    chk("mrst_busy", {7'b0, spis_busy}, 8'h00);
    chk_reg("mrst_sscr", SSCR, 8'h00);
    chk_reg("mrst_sssr", SSSR, 8'h04);
    chk_reg("mrst_ssdr", SSDR, 8'h00);
    ss_high();
    configure(1'b0, 1'b0, 1'b0);
    sfr_write(SSDR, 8'h3E);
    frame(8'h6B, 8'h3E, 8'h6B);
    chk_reg("mrst_next_sssr", SSSR, 8'h05);
    sfr_write(SSSR, 8'h03);

    // spe cleared mid-frame
    configure(1'b0, 1'b1, 1'b0);
    sfr_write(SSDR, 8'h55);
    ss_low();
    spi_byte(8'hF0, 3, m1);
    sfr_write(SSCR, 8'h80);
    repeat (3) @(negedge CLK);
    chk("spe0_busy", {7'b0, spis_busy}, 8'h00);
    chk("spe0_miso", {7'b0, MISO}, 8'h00);
    chk("spe0_int", {7'b0, INT}, 8'h00);
    chk_reg("spe0_sscr_kept", SSCR, 8'h80);
    chk_reg("spe0_sssr", SSSR, 8'h04);
    chk_reg("spe0_ssdr", SSDR, 8'h00);
    ss_high();
    configure(1'b0, 1'b1, 1'b0);
    sfr_write(SSDR, 8'h9C);
    frame(8'h27, 8'h9C, 8'h27);
    chk_reg("spe0_next_sssr", SSSR, 8'h05);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
